// File: rtl/sample02_list_scheduler.sv
// sample02_list_scheduler
// Resource-constrained list scheduler/executor for the sample02 logic graph
// (ops f,g,h,i,j,k,l,o,p). Ready ops are issued each RUN cycle in fixed
// priority order (lowest op index first), limited by N_AND/N_OR/N_NOT shared
// units. A result becomes visible to successors only in the following step.
//
// Optional feature: define SCHED_STALL_EN to add the 'stall' input, which
// freezes issue, results and the step counter while high in RUN.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   start       begin evaluation (sampled only in IDLE)
//   a..e        operands, captured on accepted start
//   stall       (SCHED_STALL_EN only) hold the schedule in RUN
//   busy        high in RUN and DONE
//   done        one-cycle pulse when o/p are final
//   o, p        results !l and !k, held until the next run completes
//   steps       control steps used by the last completed run
//   issue_mask  ops issued this cycle (f0 g1 h2 i3 j4 k5 l6 o7 p8)
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | issuing/executing ops, one control step per cycle
// S_DONE | one-cycle done pulse, then back to S_IDLE

module sample02_list_scheduler #(
  parameter int N_AND = 1,
  parameter int N_OR  = 1,
  parameter int N_NOT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
`ifdef SCHED_STALL_EN
  input  logic       stall,
`endif
  output logic       busy,
  output logic       done,
  output logic       o,
  output logic       p,
  output logic [3:0] steps,
  output logic [8:0] issue_mask
);

  if (N_AND < 1 || N_AND > 2) begin : g_bad_n_and
    $error("N_AND must be in 1..2");
  end
  if (N_OR < 1 || N_OR > 3) begin : g_bad_n_or
    $error("N_OR must be in 1..3");
  end
  if (N_NOT < 1 || N_NOT > 2) begin : g_bad_n_not
    $error("N_NOT must be in 1..2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Unit type of each op, bit index = op index
  localparam logic [8:0] M_AND = 9'b001100010; // g k l
  localparam logic [8:0] M_OR  = 9'b000011101; // f h i j
  localparam logic [8:0] M_NOT = 9'b110000000; // o p

  state_t     r_state, w_state_next;
  logic       r_a, r_b, r_c, r_d, r_e;
  logic [8:0] r_done_vec;
  logic [8:0] r_res;
  logic [3:0] r_cnt;
  logic       r_o, r_p;
  logic [3:0] r_steps;

  logic       w_stall;
  logic       w_run_act;
  logic [8:0] w_pred_ok;
  logic [8:0] w_ready;
  logic [8:0] w_issue;
  logic [8:0] w_val;
  logic [8:0] w_res_next;
  logic [8:0] w_dv_next;
  logic [3:0] w_cnt_next;
  logic       w_fin;

`ifdef SCHED_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_run_act = (r_state == S_RUN) && !w_stall;

  assign w_pred_ok[0] = 1'b1;
  assign w_pred_ok[1] = 1'b1;
  assign w_pred_ok[2] = r_done_vec[0] & r_done_vec[1];
  assign w_pred_ok[3] = r_done_vec[2];
  assign w_pred_ok[4] = r_done_vec[0] & r_done_vec[1];
  assign w_pred_ok[5] = r_done_vec[3] & r_done_vec[4];
  assign w_pred_ok[6] = r_done_vec[5];
  assign w_pred_ok[7] = r_done_vec[6];
  assign w_pred_ok[8] = r_done_vec[5];

  assign w_ready = ~r_done_vec & w_pred_ok;

  // Priority issue: scan ops lowest index first, granting each type until
  // its unit pool is exhausted.
  always_comb begin
    int n_and;
    int n_or;
    int n_not;
    w_issue = '0;
    n_and   = 0;
    n_or    = 0;
    n_not   = 0;
    if (w_run_act) begin
      for (int i = 0; i < 9; i++) begin
        if (w_ready[i]) begin
          if (M_AND[i] && n_and < N_AND) begin
            w_issue[i] = 1'b1;
            n_and      = n_and + 1;
          end else if (M_OR[i] && n_or < N_OR) begin
            w_issue[i] = 1'b1;
            n_or       = n_or + 1;
          end else if (M_NOT[i] && n_not < N_NOT) begin
            w_issue[i] = 1'b1;
            n_not      = n_not + 1;
          end
        end
      end
    end
  end

  // Op functions read only registered operands/results: no same-step chaining
  assign w_val[0] = r_a | r_b;
  assign w_val[1] = r_b & r_d;
  assign w_val[2] = r_res[0] | r_res[1];
  assign w_val[3] = r_c | r_res[2];
  assign w_val[4] = r_e | r_res[0] | r_res[1];
  assign w_val[5] = r_res[3] & r_res[4];
  assign w_val[6] = r_d & r_e & r_res[5];
  assign w_val[7] = ~r_res[6];
  assign w_val[8] = ~r_res[5];

  assign w_res_next = (r_res & ~w_issue) | (w_val & w_issue);
  assign w_dv_next  = r_done_vec | w_issue;
  assign w_cnt_next = (r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1;
  assign w_fin      = w_run_act && (&w_dv_next);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_fin) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    issue_mask = w_issue;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_c        <= 1'b0;
      r_d        <= 1'b0;
      r_e        <= 1'b0;
      r_done_vec <= '0;
      r_res      <= '0;
      r_cnt      <= '0;
      r_o        <= 1'b0;
      r_p        <= 1'b0;
      r_steps    <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_a        <= a;
        r_b        <= b;
        r_c        <= c;
        r_d        <= d;
        r_e        <= e;
        r_done_vec <= '0;
        r_res      <= '0;
        r_cnt      <= '0;
      end else if (w_run_act) begin
        r_done_vec <= w_dv_next;
        r_res      <= w_res_next;
        r_cnt      <= w_cnt_next;
        if (w_fin) begin
          r_o     <= ~w_res_next[6];
          r_p     <= ~w_res_next[5];
          r_steps <= w_cnt_next;
        end
      end
    end
  end

  assign o     = r_o;
  assign p     = r_p;
  assign steps = r_steps;

endmodule

// File: tb/tb_sample02_list_scheduler.sv
module tb_sample02_list_scheduler;

  typedef struct packed {
    logic       o;
    logic       p;
    logic [3:0] steps;
    logic [7:0] cyc;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
  logic       stall = 1'b0;
  logic       sel = 1'b0;

  logic       busy0, done0, o0, p0;
  logic [3:0] steps0;
  logic [8:0] mask0;
  logic       busy1, done1, o1, p1;
  logic [3:0] steps1;
  logic [8:0] mask1;

  logic       mon_busy, mon_done, mon_o, mon_p;
  logic [3:0] mon_steps;
  logic [8:0] mon_mask;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] exp_mask_q[$];
  res_t       exp_res_q[$];

  always #5 clk = ~clk;

  sample02_list_scheduler dut (
    .clk(clk), .rst(rst), .start(start0),
    .a(a), .b(b), .c(c), .d(d), .e(e),
`ifdef SCHED_STALL_EN
    .stall(stall),
`endif
    .busy(busy0), .done(done0), .o(o0), .p(p0),
    .steps(steps0), .issue_mask(mask0)
  );

  sample02_list_scheduler #(.N_AND(1), .N_OR(2), .N_NOT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a), .b(b), .c(c), .d(d), .e(e),
`ifdef SCHED_STALL_EN
    .stall(1'b0),
`endif
    .busy(busy1), .done(done1), .o(o1), .p(p1),
    .steps(steps1), .issue_mask(mask1)
  );

  assign mon_busy  = sel ? busy1  : busy0;
  assign mon_done  = sel ? done1  : done0;
  assign mon_o     = sel ? o1     : o0;
  assign mon_p     = sel ? p1     : p0;
  assign mon_steps = sel ? steps1 : steps0;
  assign mon_mask  = sel ? mask1  : mask0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_masks(input logic [8:0] m[$]);
    foreach (m[i]) exp_mask_q.push_back(m[i]);
  endtask

  task automatic push_res(input logic eo, input logic ep, input int st, input int cy);
    res_t r;
    r.o = eo; r.p = ep; r.steps = 4'(st); r.cyc = 8'(cy);
    exp_res_q.push_back(r);
  endtask

  // Starts one run on the selected DUT, then drives start/stall per cycle:
  // start is raised in cycles s1/s2 (0 = never), stall in cycles st_lo..st_hi.
  task automatic do_run(input logic which, input logic [4:0] ops,
                        input int s1, input int s2, input int st_lo, input int st_hi);
    logic [8:0] em;
    res_t       er;
    bit         seen;
    seen = 0;
    @(negedge clk);
    sel = which;
    {a, b, c, d, e} = ops;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    for (int k = 1; k <= 25 && !seen; k++) begin
      @(posedge clk);
      #1;
      start0 = !which && (k == s1 || k == s2);
      start1 = which && (k == s1 || k == s2);
      stall  = (k >= st_lo && k <= st_hi);
      if (k == 3 && s1 != 0) {a, b, c, d, e} = ~ops;
      @(negedge clk);
      if (mon_done) begin
        seen = 1;
        chk("mask_q_drained", 16'(exp_mask_q.size()), 16'd0);
        if (exp_res_q.size() == 0) begin
          chk("res_q_nonempty", 16'd0, 16'd1);
        end else begin
          er = exp_res_q.pop_front();
          chk("o", 16'(mon_o), 16'(er.o));
          chk("p", 16'(mon_p), 16'(er.p));
          chk("steps", 16'(mon_steps), 16'(er.steps));
          chk("done_cycle", 16'(k), 16'(er.cyc));
          chk("busy_in_done", 16'(mon_busy), 16'd1);
          chk("mask_in_done", 16'(mon_mask), 16'd0);
        end
      end else if (mon_busy) begin
        if (exp_mask_q.size() == 0) begin
          chk("mask_q_nonempty", 16'(mon_mask), 16'h1ff);
        end else begin
          em = exp_mask_q.pop_front();
          chk("issue_mask", 16'(mon_mask), 16'(em));
        end
      end
    end
    if (!seen) chk("done_timeout", 16'd0, 16'd1);
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    stall  = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 16'(mon_done), 16'd0);
    chk("busy_after", 16'(mon_busy), 16'd0);
    exp_mask_q.delete();
    exp_res_q.delete();
  endtask

  initial begin
    logic [8:0] m_def[$];
    logic [8:0] m_or2[$];
    logic [8:0] m_stall[$];
    m_def   = '{9'h003, 9'h004, 9'h008, 9'h010, 9'h020, 9'h140, 9'h080};
    m_or2   = '{9'h003, 9'h014, 9'h008, 9'h020, 9'h140, 9'h080};
    m_stall = '{9'h003, 9'h000, 9'h000, 9'h004, 9'h008, 9'h010, 9'h020, 9'h140, 9'h080};

    // Reset state
    #12;
    chk("rst_busy", 16'(busy0), 16'd0);
    chk("rst_done", 16'(done0), 16'd0);
    chk("rst_o", 16'(o0), 16'd0);
    chk("rst_p", 16'(p0), 16'd0);
    chk("rst_steps", 16'(steps0), 16'd0);
    chk("rst_mask", 16'(mask0), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // a=1 b=0 c=0 d=1 e=1 -> o=0 p=0, 7 steps
    push_masks(m_def);
    push_res(1'b0, 1'b0, 7, 8);
    do_run(1'b0, 5'b10011, 0, 0, 1, 0);

    // All zero, start pulsed mid-run (operands also change) and in DONE
    push_masks(m_def);
    push_res(1'b1, 1'b1, 7, 8);
    do_run(1'b0, 5'b00000, 3, 8, 1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("no_second_run", 16'(busy0), 16'd0);
    end
    push_masks(m_def);
    push_res(1'b0, 1'b0, 7, 8);
    do_run(1'b0, 5'b10011, 0, 0, 1, 0);

    // All zero -> o=1 p=1
    push_masks(m_def);
    push_res(1'b1, 1'b1, 7, 8);
    do_run(1'b0, 5'b00000, 0, 0, 1, 0);

    // Reset during RUN step 3
    @(negedge clk);
    sel = 1'b0;
    {a, b, c, d, e} = 5'b10011;
    start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_busy", 16'(busy0), 16'd0);
    chk("midrst_o", 16'(o0), 16'd0);
    chk("midrst_p", 16'(p0), 16'd0);
    chk("midrst_steps", 16'(steps0), 16'd0);
    chk("midrst_mask", 16'(mask0), 16'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_done", 16'(done0), 16'd0);
    end
    rst = 1'b1;
    push_masks(m_def);
    push_res(1'b0, 1'b0, 7, 8);
    do_run(1'b0, 5'b10011, 0, 0, 1, 0);

    // N_OR=2 instance: a=0 b=1 c=0 d=0 e=0 -> o=1 p=0, 6 steps
    push_masks(m_or2);
    push_res(1'b1, 1'b0, 6, 7);
    do_run(1'b1, 5'b01000, 0, 0, 1, 0);

`ifdef SCHED_STALL_EN
    // Stall during steps 2-3
    push_masks(m_stall);
    push_res(1'b0, 1'b0, 7, 10);
    do_run(1'b0, 5'b10011, 0, 0, 2, 3);
`else
    m_stall.delete();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sample02_list_scheduler.md
Name: sample02_list_scheduler

Overview:
- Hardware list scheduler and executor for the sample02 logic graph (ops f,g,h,i,j,k,l,o,p).
- Evaluates the graph over multiple control steps on a bounded pool of shared AND, OR and NOT units.
- Each cycle it issues ready ops in fixed priority order, up to the unit limits.
- Used to measure resource-constrained schedule length against the single-cycle combinational sample02 netlist.

Parameters:
- N_AND, 1, AND units per step (range 1..2).
- N_OR, 1, OR units per step (range 1..3). A 3-input OR counts as one op.
- N_NOT, 1, NOT units per step (range 1..2).
- Any value of 0 is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin evaluation; sampled only in IDLE.
- a, b, c, d, e  in  1 each  operands, captured on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when o and p are final.
- o  out  1  result !l.
- p  out  1  result !k.
- steps  out  4  number of control steps used by the last run.
- issue_mask  out  9  ops issued this cycle. Bit index: f0 g1 h2 i3 j4 k5 l6 o7 p8.

Behaviour:
- Op table (type, predecessors):
  - f: OR(a,b)
  - g: AND(b,d)
  - h: OR(f,g)
  - i: OR(c,h)
  - j: OR(e,f,g)
  - k: AND(i,j)
  - l: AND(d,e,k)
  - o: NOT(l)
  - p: NOT(k)
- Reset (rst=0, async): state=IDLE; done_vec, result regs, captured operands, o, p, busy, done, issue_mask and steps all cleared to 0. Reset mid-run aborts with no done pulse.
- IDLE:
  - start=1: capture a..e, clear done_vec and step counter, go to RUN.
  - start=0: remain in IDLE.
- RUN, each cycle:
  - ready = not done_vec AND all predecessors done.
  - Per unit type, issue the lowest-index ready ops, up to N_<type> of them.
  - Issued ops compute from registered values. Result and done bit are written at the clock edge.
  - A result becomes visible to successors in the next step; no same-step chaining.
  - issue_mask reflects the ops issued this cycle (combinational from state); it is 0 outside RUN.
  - Step counter increments every RUN cycle.
  - When done_vec becomes all-ones: o <= !l, p <= !k, steps <= counter, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then return to IDLE.
- o, p and steps hold their values until the next run completes.
- start while busy is ignored and not queued.
- start asserted in the DONE cycle is ignored. It is accepted on the first IDLE cycle in which it is high.
- Latency from accepted start: S RUN cycles, then the done pulse on cycle S+1.
  - Default 1/1/1: S=7.
  - N_OR>=2: S=6, which equals the critical path f-h-i-k-l-o.
- Counter saturates at 15; it cannot be reached with legal parameters.

Optional Feature:
- Macro SCHED_STALL_EN adds input port stall (1 bit).
- With the macro, stall=1 in RUN means:
  - no issue, and issue_mask=0;
  - done_vec, results and the step counter are frozen;
  - state stays RUN.
- With the macro, stall has no effect in IDLE or DONE.
- Without the macro: no stall port, and every RUN cycle issues.

Test Plan:
- Default params, start with a=1 b=0 c=0 d=1 e=1:
  - issue_mask sequence 003, 004, 008, 010, 020, 140, 080;
  - done pulse on cycle 8 with o=0, p=0, steps=7.
- Default params, all inputs 0: o=1, p=1, steps=7, done pulsed exactly one cycle, busy low afterwards.
- N_OR=2, inputs a=0 b=1 c=0 d=0 e=0:
  - issue_mask sequence 003, 014, 008, 020, 140, 080;
  - o=1, p=0, steps=6.
- Start pulsed during RUN, and again in the DONE cycle:
  - ignored, with no second run;
  - a new start in IDLE with a=1 d=1 e=1 gives o=0, p=0.
- Drop rst to 0 in RUN step 3:
  - all outputs 0 immediately, with no done pulse;
  - after release, a fresh start runs a full 7 steps.
- SCHED_STALL_EN defined, default params, a=1 b=0 c=0 d=1 e=1, stall=1 during steps 2-3 (i.e., after the step-1 issue):
  - issue_mask 003, 000, 000, 004, 008, 010, 020, 140, 080;
  - done on cycle 10, steps=7, o=0, p=0.
